// File: rtl/rdmap_corner_turn_reader.sv
// Corner-turn reader for the velocity FFT.
// Range-FFT results sit chirp-major in BRAM (addr = chirp*sample_num + bin).
// This block reads them back bin-major and emits one chirp_num-long packet
// per range bin on a valid/sop/eop stream. There is no backpressure.
module rdmap_corner_turn_reader #(
    parameter int ADDR_W  = 17,
    parameter int RD_LAT  = 2,
    parameter int GAP_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       sample_num,
    input  logic [15:0]       chirp_num,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic [31:0]       data_out,
    output logic              data_valid,
    output logic              data_sop,
    output logic              data_eop,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    typedef enum logic [1:0] {IDLE, RUN, GAP, FLUSH} state_t;

    // Per-read tags travel alongside the BRAM latency.
    typedef struct packed {
        logic valid;
        logic sop;
        logic eop;
    } tag_t;

    // GAP_CYC == 0 never enters GAP, so the terminal count is irrelevant then.
    localparam logic [7:0] GAP_LAST   = (GAP_CYC > 0) ? 8'(GAP_CYC - 1) : 8'd0;
    // FLUSH lasts RD_LAT+1 cycles: counts 0..RD_LAT.
    localparam logic [3:0] FLUSH_LAST = 4'(RD_LAT);

    state_t              state_q, state_d;
    logic [15:0]         sample_num_q, sample_num_d;
    logic [15:0]         chirp_num_q, chirp_num_d;
    logic [15:0]         bin_q, bin_d;
    logic [15:0]         chirp_q, chirp_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   hold_addr_q, hold_addr_d;
    logic [7:0]          gap_cnt_q, gap_cnt_d;
    logic [3:0]          flush_cnt_q, flush_cnt_d;
    logic                done_q, done_d;
    logic                cfg_err_q, cfg_err_d;
    logic                last_chirp;
    logic                last_bin;
    tag_t                issue_tag;

    tag_t                tag_sr_q [RD_LAT];
    logic [31:0]         data_out_q;
    logic                data_valid_q;
    logic                data_sop_q;
    logic                data_eop_q;

    assign last_chirp = (chirp_q == chirp_num_q - 16'd1);
    assign last_bin   = (bin_q == sample_num_q - 16'd1);

    // Next-state, address walk and issue-side tag generation.
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_d      = state_q;
        sample_num_d = sample_num_q;
        chirp_num_d  = chirp_num_q;
        bin_d        = bin_q;
        chirp_d      = chirp_q;
        addr_d       = addr_q;
        hold_addr_d  = hold_addr_q;
        gap_cnt_d    = gap_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        done_d       = 1'b0;
        cfg_err_d    = 1'b0;
        issue_tag    = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (sample_num != 16'd0 && chirp_num != 16'd0) begin
                        sample_num_d = sample_num;
                        chirp_num_d  = chirp_num;
                        bin_d        = 16'd0;
                        chirp_d      = 16'd0;
                        addr_d       = '0;
                        state_d      = RUN;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end

            RUN: begin
                issue_tag.valid = 1'b1;
                issue_tag.sop   = (chirp_q == 16'd0);
                issue_tag.eop   = last_chirp;
                // Remember the issued address so rd_addr holds during GAP/FLUSH/IDLE.
                hold_addr_d     = addr_q;
                if (!last_chirp) begin
                    chirp_d = chirp_q + 16'd1;
                    // Stride by one chirp row; wide sum, wrapped to the BRAM width.
                    addr_d  = ADDR_W'({16'd0, addr_q} + {{ADDR_W{1'b0}}, sample_num_q});
                end else if (!last_bin) begin
                    bin_d   = bin_q + 16'd1;
                    chirp_d = 16'd0;
                    addr_d  = ADDR_W'({{ADDR_W{1'b0}}, bin_q + 16'd1});
                    if (GAP_CYC > 0) begin
                        gap_cnt_d = 8'd0;
                        state_d   = GAP;
                    end
                end else begin
                    flush_cnt_d = 4'd0;
                    state_d     = FLUSH;
                end
            end

            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = RUN;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end

            FLUSH: begin
                // Wait for the last read to leave the output register.
                if (flush_cnt_q == FLUSH_LAST) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q + 4'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Control state register; reset aborts a frame immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sample_num_q <= '0;
            chirp_num_q  <= '0;
            bin_q        <= '0;
            chirp_q      <= '0;
            addr_q       <= '0;
            hold_addr_q  <= '0;
            gap_cnt_q    <= '0;
            flush_cnt_q  <= '0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q      <= state_d;
            sample_num_q <= sample_num_d;
            chirp_num_q  <= chirp_num_d;
            bin_q        <= bin_d;
            chirp_q      <= chirp_d;
            addr_q       <= addr_d;
            hold_addr_q  <= hold_addr_d;
            gap_cnt_q    <= gap_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            done_q       <= done_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    // Tag delay line matching BRAM latency, then the registered output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the tag line is reset (unlike a data memory) so an abort
            // cannot leak stale valid/eop beats after reset is released.
            for (int i = 0; i < RD_LAT; i++) begin
                tag_sr_q[i] <= '0;
            end
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            data_sop_q   <= 1'b0;
            data_eop_q   <= 1'b0;
        end else begin
            tag_sr_q[0] <= issue_tag;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_sr_q[i] <= tag_sr_q[i-1];
            end
            data_valid_q <= tag_sr_q[RD_LAT-1].valid;
            data_sop_q   <= tag_sr_q[RD_LAT-1].sop;
            data_eop_q   <= tag_sr_q[RD_LAT-1].eop;
            data_out_q   <= tag_sr_q[RD_LAT-1].valid ? rd_data : 32'd0;
        end
    end

    assign rd_en      = (state_q == RUN);
    assign rd_addr    = rd_en ? addr_q : hold_addr_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign cfg_err    = cfg_err_q;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign data_sop   = data_sop_q;
    assign data_eop   = data_eop_q;

endmodule

// File: tb/tb_rdmap_corner_turn_reader.sv
// Bench for rdmap_corner_turn_reader. Four builds run side by side:
//   0: RD_LAT=2 GAP_CYC=4, 1: RD_LAT=2 GAP_CYC=0,
//   2: RD_LAT=1 GAP_CYC=4, 3: RD_LAT=4 GAP_CYC=4.
// Each has a BRAM model returning its own read address as data.
module tb_rdmap_corner_turn_reader;

    localparam int NI = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NI-1:0]        start_v = '0;
    logic [15:0]          sample_num = 16'd0;
    logic [15:0]          chirp_num  = 16'd0;
    logic [NI-1:0]        rd_en_v, data_valid_v, sop_v, eop_v, busy_v, done_v, cfg_err_v;
    logic [NI-1:0][16:0]  rd_addr_v;
    logic [NI-1:0][31:0]  rd_data_v, data_out_v;

    function automatic int lat_of(input int g);
        return (g == 2) ? 1 : ((g == 3) ? 4 : 2);
    endfunction

    function automatic int gap_of(input int g);
        return (g == 1) ? 0 : 4;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int LAT = (g == 2) ? 1 : ((g == 3) ? 4 : 2);
        localparam int GAP = (g == 1) ? 0 : 4;
        logic [31:0] pipe [LAT];

        // BRAM model: data = address, garbage when not read.
        always @(posedge clk) begin
            pipe[0] <= rd_en_v[g] ? {15'd0, rd_addr_v[g]} : 32'hBAD0_0000;
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end
        assign rd_data_v[g] = pipe[LAT-1];

        rdmap_corner_turn_reader #(
            .ADDR_W (17),
            .RD_LAT (LAT),
            .GAP_CYC(GAP)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start_v[g]),
            .sample_num(sample_num),
            .chirp_num (chirp_num),
            .rd_en     (rd_en_v[g]),
            .rd_addr   (rd_addr_v[g]),
            .rd_data   (rd_data_v[g]),
            .data_out  (data_out_v[g]),
            .data_valid(data_valid_v[g]),
            .data_sop  (sop_v[g]),
            .data_eop  (eop_v[g]),
            .busy      (busy_v[g]),
            .done      (done_v[g]),
            .cfg_err   (cfg_err_v[g])
        );
    end

    // Scoreboard records.
    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
    } beat_t;

    typedef struct packed {
        logic [16:0] addr;
        logic        pkt_first;
    } rd_t;

    beat_t exp_beat_q[$];
    rd_t   exp_rd_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor state.
    int          sel = 0;
    bit          mon_en = 1'b0;
    bit          frame_active = 1'b0;
    int          cyc = 0;
    bit          have_rd;
    int          first_rd_cyc, first_dv_cyc, last_rd_cyc, last_eop_cyc;
    logic [16:0] last_addr;
    int          beats_seen, eops_seen, sops_seen;
    rd_t         r_mon;
    beat_t       b_mon;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: sampled on the falling edge, compared against the queues.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rd_en_v[sel]) begin
                if (exp_rd_q.size() == 0) begin
                    check("rd_en_unexpected", 64'(rd_en_v[sel]), 64'd0);
                end else begin
                    r_mon = exp_rd_q.pop_front();
                    check("rd_addr", 64'(rd_addr_v[sel]), 64'(r_mon.addr));
                    if (have_rd)
                        check("rd_gap", 64'(cyc - last_rd_cyc - 1),
                              64'(r_mon.pkt_first ? gap_of(sel) : 0));
                    else
                        first_rd_cyc = cyc;
                end
                have_rd     = 1'b1;
                last_rd_cyc = cyc;
                last_addr   = rd_addr_v[sel];
            end else if (busy_v[sel] && have_rd) begin
                check("rd_addr_hold", 64'(rd_addr_v[sel]), 64'(last_addr));
            end

            if (data_valid_v[sel]) begin
                if (exp_beat_q.size() == 0) begin
                    check("dv_unexpected", 64'(data_valid_v[sel]), 64'd0);
                end else begin
                    b_mon = exp_beat_q.pop_front();
                    check("beat{data,sop,eop}", 64'({data_out_v[sel], sop_v[sel], eop_v[sel]}),
                          64'(b_mon));
                end
                if (first_dv_cyc < 0) begin
                    first_dv_cyc = cyc;
                    check("first_latency", 64'(cyc - first_rd_cyc), 64'(lat_of(sel) + 1));
                end
                beats_seen++;
                if (sop_v[sel]) sops_seen++;
                if (eop_v[sel]) begin
                    eops_seen++;
                    last_eop_cyc = cyc;
                end
            end else begin
                check("idle_outputs_zero", 64'({data_out_v[sel], sop_v[sel], eop_v[sel]}), 64'd0);
            end

            if (done_v[sel]) begin
                check("done_expected", 64'(frame_active), 64'd1);
                check("done_after_eop", 64'(cyc - last_eop_cyc), 64'd1);
                check("busy_at_done", 64'(busy_v[sel]), 64'd0);
                frame_active = 1'b0;
            end
        end
    end

    // Expected read order and beats from the chirp-major layout.
    task automatic push_model(input int sn, input int cn);
        logic [16:0] a;
        for (int b = 0; b < sn; b++) begin
            for (int c = 0; c < cn; c++) begin
                a = 17'((c * sn + b) & 32'h1FFFF);
                exp_rd_q.push_back('{addr: a, pkt_first: (c == 0 && b != 0)});
                exp_beat_q.push_back('{data: {15'd0, a}, sop: (c == 0), eop: (c == cn - 1)});
            end
        end
    endtask

    task automatic run_frame(input int inst, input int sn, input int cn, input bit exp_err,
                             input bit poke);
        int budget;
        sel          = inst;
        have_rd      = 1'b0;
        first_rd_cyc = -1;
        first_dv_cyc = -1;
        last_eop_cyc = 0;
        beats_seen   = 0;
        eops_seen    = 0;
        sops_seen    = 0;
        if (!exp_err) begin
            push_model(sn, cn);
            frame_active = 1'b1;
        end
        @(posedge clk);
        #1;
        sample_num     = 16'(sn);
        chirp_num      = 16'(cn);
        start_v[inst]  = 1'b1;
        @(posedge clk);
        #1;
        start_v[inst]  = 1'b0;
        sample_num     = 16'd7;   // changes after start must not matter
        chirp_num      = 16'd9;
        @(negedge clk);
        check("cfg_err_after_start", 64'(cfg_err_v[inst]), 64'(exp_err));
        check("busy_after_start", 64'(busy_v[inst]), 64'(!exp_err));
        if (exp_err) begin
            repeat (4) begin
                @(negedge clk);
                check("rejected_stays_idle",
                      64'({cfg_err_v[inst], busy_v[inst], rd_en_v[inst], data_valid_v[inst]}), 64'd0);
            end
            return;
        end

        budget = sn * cn + sn * (gap_of(inst) + 1) + 40;
        for (int i = 0; i < budget && frame_active; i++) begin
            @(posedge clk);
            if (poke && (i == 50 || i == 60)) begin
                #1;
                sample_num    = (i == 50) ? 16'd5 : 16'd0;
                chirp_num     = (i == 50) ? 16'd5 : 16'd0;
                start_v[inst] = 1'b1;
                @(posedge clk);
                #1;
                start_v[inst] = 1'b0;
                @(negedge clk);
                check("start_while_busy_no_cfg_err", 64'(cfg_err_v[inst]), 64'd0);
            end
        end
        check("done_within_budget", 64'(frame_active), 64'd0);
        check("beat_count", 64'(beats_seen), 64'(sn * cn));
        check("eop_count", 64'(eops_seen), 64'(sn));
        check("sop_count", 64'(sops_seen), 64'(sn));
        check("last_rd_addr", 64'(last_addr), 64'(((cn - 1) * sn + sn - 1) & 32'h1FFFF));
        check("scoreboard_drained", 64'(exp_beat_q.size() + exp_rd_q.size()), 64'd0);
        exp_beat_q.delete();
        exp_rd_q.delete();
        frame_active = 1'b0;
        repeat (6) @(negedge clk);  // a second done here would be flagged
    endtask

    typedef struct {
        int inst;
        int sn;
        int cn;
        bit err;
        bit poke;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs[0] = '{inst: 0, sn: 4,    cn: 4,  err: 1'b0, poke: 1'b0};
        vecs[1] = '{inst: 1, sn: 3,    cn: 1,  err: 1'b0, poke: 1'b0};
        vecs[2] = '{inst: 0, sn: 0,    cn: 4,  err: 1'b1, poke: 1'b0};
        vecs[3] = '{inst: 0, sn: 4,    cn: 0,  err: 1'b1, poke: 1'b0};
        vecs[4] = '{inst: 0, sn: 0,    cn: 0,  err: 1'b1, poke: 1'b0};
        vecs[5] = '{inst: 2, sn: 2,    cn: 2,  err: 1'b0, poke: 1'b0};
        vecs[6] = '{inst: 3, sn: 2,    cn: 2,  err: 1'b0, poke: 1'b0};
        vecs[7] = '{inst: 0, sn: 3,    cn: 5,  err: 1'b0, poke: 1'b0};
        vecs[8] = '{inst: 1, sn: 1,    cn: 1,  err: 1'b0, poke: 1'b0};
        vecs[9] = '{inst: 1, sn: 2048, cn: 32, err: 1'b0, poke: 1'b1};

        // Reset state of every build.
        repeat (3) @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            check("reset_outputs_zero",
                  64'({rd_en_v[g], rd_addr_v[g], data_valid_v[g], sop_v[g], eop_v[g],
                       busy_v[g], done_v[g], cfg_err_v[g]}), 64'd0);
            check("reset_data_zero", 64'(data_out_v[g]), 64'd0);
        end
        rst    = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_frame(vecs[i].inst, vecs[i].sn, vecs[i].cn, vecs[i].err, vecs[i].poke);
        end

        // Mid-packet reset on build 0: everything clears, no done follows.
        mon_en = 1'b0;
        sel    = 0;
        @(posedge clk);
        #1;
        sample_num = 16'd4;
        chirp_num  = 16'd4;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rd_en_before_reset", 64'(rd_en_v[0]), 64'd1);
        rst = 1'b1;
        #1;
        check("abort_outputs_zero",
              64'({rd_en_v[0], rd_addr_v[0], data_valid_v[0], sop_v[0], eop_v[0],
                   busy_v[0], done_v[0], cfg_err_v[0]}), 64'd0);
        check("abort_data_zero", 64'(data_out_v[0]), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("no_activity_after_abort",
                  64'({done_v[0], busy_v[0], data_valid_v[0], rd_en_v[0]}), 64'd0);
        end
        mon_en = 1'b1;
        run_frame(0, 2, 2, 1'b0, 1'b0);

        // Large frame with start attempts while busy.
        run_frame(vecs[9].inst, vecs[9].sn, vecs[9].cn, vecs[9].err, vecs[9].poke);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
